// File: rtl/led_fader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_fader_pkg
// Description : Shared types for the LED fader. Holds the fade state encoding
//               used by the FSM in led_fader.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package led_fader_pkg;

    // OFF holds duty at 0 and ON holds duty at MAX. The two RAMP states
    // step duty by one every STEP_DIV clocks.
    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } fade_state_t;

endpackage : led_fader_pkg
`default_nettype wire

// File: rtl/led_fader_if.sv
`default_nettype none
// ============================================================================
// Module      : led_fader_if
// Description : Bundle between the blink generator, the LED fader and the
//               board LED pin.
// Signals     : level_in - target level from the blinker (1 = fade to full)
//               led_out  - PWM LED drive
//               busy     - high while a ramp is in progress
//               duty     - current (un-mapped) brightness
// Modports    : master - drives level_in and observes the fader outputs
//               slave  - the fader side
// Revision    : 1.0 - initial release
// ============================================================================
interface led_fader_if #(
    parameter int PWM_BITS = 8
);
    logic                level_in;
    logic                led_out;
    logic                busy;
    logic [PWM_BITS-1:0] duty;

    modport master (
        output level_in,
        input  led_out,
        input  busy,
        input  duty
    );

    modport slave (
        input  level_in,
        output led_out,
        output busy,
        output duty
    );
endinterface : led_fader_if
`default_nettype wire

// File: rtl/led_pwm.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm
// Description : Free-running PWM generator. A shadow register captures the
//               compare value once per period, when the counter is at MAX.
//               A new brightness therefore always starts on a clean period
//               boundary.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               compare  - requested high time in clocks per period
//               led_out  - PWM output
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PWM_BITS-1:0] compare,
    output logic                led_out
);

    localparam logic [PWM_BITS-1:0] c_max = '1;

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] shadow_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q <= '0;
            shadow_q  <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            if (pwm_cnt_q == c_max) begin
                shadow_q <= compare;
            end
        end
    end

    // cnt < MAX can never cover all 2^N counts, so MAX is forced to a solid
    // high. A compare of 0 gives a solid low without any special case.
    assign led_out = (shadow_q == c_max) || (pwm_cnt_q < shadow_q);

endmodule : led_pwm
`default_nettype wire

// File: rtl/led_fader.sv
`default_nettype none
// ============================================================================
// Module      : led_fader
// Description : Turns the blinker's square-wave level into a linear
//               brightness ramp on a PWM-driven LED. On each level edge the
//               duty ramps by one every STEP_DIV clocks toward 0 or MAX. A
//               level change during a ramp reverses it from the current duty.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               bus      - led_fader_if slave (level_in, led_out, busy, duty)
// Config      : LED_FADER_GAMMA_EN - when defined, the PWM compare value is
//               duty*duty >> PWM_BITS, with MAX kept at MAX. The duty port is
//               always the un-mapped value.
// Revision    : 1.0 - initial release
// ============================================================================
module led_fader
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 48_828
) (
    input  logic         clk,
    input  logic         reset_n,
    led_fader_if.slave   bus
);

    localparam logic [PWM_BITS-1:0] c_max    = '1;
    localparam int                  c_step_w = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_step_w-1:0] c_step_last = c_step_w'(STEP_DIV - 1);

    fade_state_t         state_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;
    logic [c_step_w-1:0] step_q;
    logic                busy_q;
    logic                w_step_wrap;
    logic [PWM_BITS-1:0] w_compare;

    assign w_step_wrap = (step_q == c_step_last);

    // Duty after this edge. It changes only on a step wrap inside a ramp and
    // saturates at both ends.
    always_comb begin
        duty_d = duty_q;
        if (w_step_wrap) begin
            case (state_q)
                RAMP_UP:   if (duty_q != c_max) duty_d = duty_q + 1'b1;
                RAMP_DOWN: if (duty_q != '0)    duty_d = duty_q - 1'b1;
                default:   duty_d = duty_q;
            endcase
        end
    end

    // The level check comes before the end-of-ramp check in both ramps. If
    // the final step and a reversal happen on the same edge, the duty still
    // takes that step, and the ramp then turns around instead of settling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= OFF;
            duty_q  <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            case (state_q)
                OFF: begin
                    step_q <= '0;
                    if (bus.level_in) begin
                        state_q <= RAMP_UP;
                        busy_q  <= 1'b1;
                    end
                end
                RAMP_UP: begin
                    if (!bus.level_in) begin
                        state_q <= RAMP_DOWN;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                    end else if (duty_d == c_max) begin
                        state_q <= ON;
                        step_q  <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        step_q  <= w_step_wrap ? '0 : step_q + 1'b1;
                    end
                end
                ON: begin
                    step_q <= '0;
                    if (!bus.level_in) begin
                        state_q <= RAMP_DOWN;
                        busy_q  <= 1'b1;
                    end
                end
                RAMP_DOWN: begin
                    if (bus.level_in) begin
                        state_q <= RAMP_UP;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                    end else if (duty_d == '0) begin
                        state_q <= OFF;
                        step_q  <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        step_q  <= w_step_wrap ? '0 : step_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= OFF;
                    step_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LED_FADER_GAMMA_EN
    // A square-law map makes the fade look linear to the eye. The product
    // is computed at full double width before the shift.
    logic [2*PWM_BITS-1:0] w_duty_sq;
    assign w_duty_sq = {{PWM_BITS{1'b0}}, duty_q} * {{PWM_BITS{1'b0}}, duty_q};
    assign w_compare = (duty_q == c_max) ? c_max : PWM_BITS'(w_duty_sq >> PWM_BITS);
`else
    assign w_compare = duty_q;
`endif

    led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk      (clk),
        .reset_n  (reset_n),
        .compare  (w_compare),
        .led_out  (bus.led_out)
    );

    assign bus.busy = busy_q;
    assign bus.duty = duty_q;

endmodule : led_fader
`default_nettype wire

// File: doc/led_fader.md
# led_fader

Downstream LED stage for the blink generator. Consumes the blinker's square-wave level and drives the physical LED with a PWM signal. Each level edge becomes a linear brightness ramp instead of a hard on/off step. It sits between the blink divider output and the board LED pin, in the same clock domain.

## Interface

- `PWM_BITS`, default 8: duty/counter width; the PWM period is 2^PWM_BITS clocks.
- `STEP_DIV`, default 48_828: clocks per duty step. A full ramp takes (2^PWM_BITS−1)·STEP_DIV clocks, about 0.125 s at 100 MHz.
- `clk`, input, 1: system clock, 100 MHz.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `level_in`, input, 1: target level from the blinker, synchronous to `clk`. 1 means fade to full, 0 means fade to off.
- `led_out`, output, 1: PWM LED drive.
- `busy`, output, 1: high while ramping.
- `duty`, output, PWM_BITS: current brightness, 0..2^PWM_BITS−1.

## Operation

- States (`fade_state_t`):
  - OFF: duty=0.
  - RAMP_UP.
  - ON: duty=MAX, where MAX = 2^PWM_BITS−1.
  - RAMP_DOWN.
- Transitions are level-based and evaluated every clock:
  - OFF → RAMP_UP when `level_in`=1.
  - RAMP_UP → ON when duty reaches MAX.
  - RAMP_UP → RAMP_DOWN when `level_in`=0. The ramp reverses from the current duty with no jump.
  - ON → RAMP_DOWN when `level_in`=0.
  - RAMP_DOWN → OFF when duty reaches 0.
  - RAMP_DOWN → RAMP_UP when `level_in`=1.
- Step counter:
  - Counts 0..STEP_DIV−1 while in a RAMP state.
  - At STEP_DIV−1 it wraps to 0 and duty changes by ±1.
  - It clears to 0 on every state change.
  - Duty saturates at 0 and MAX; it never wraps.
- PWM:
  - A free-running counter `pwm_cnt` runs 0..2^PWM_BITS−1 and wraps.
  - A shadow compare register loads the compare value only when `pwm_cnt`=MAX, so the new duty takes effect from the next period.
  - `led_out` = (`pwm_cnt` < compare). The exception is compare=MAX, which forces `led_out`=1 constantly.
  - Compare=0 gives `led_out`=0 constantly.
- `busy` = state is RAMP_UP or RAMP_DOWN.

## Timing

- Reset values:
  - state=OFF
  - duty=0
  - step counter=0
  - `pwm_cnt`=0
  - shadow=0
  - `led_out`=0
  - `busy`=0
- Reset is asynchronous. Asserting it mid-ramp drops `led_out` to 0 immediately. After deassertion the block resumes from OFF.
- `level_in` rising in cycle n: state=RAMP_UP and `busy`=1 after edge n+1. The first duty increment appears STEP_DIV clocks later.
- The `duty` port is registered and updates on the step edge. `led_out` reflects the new duty at the first PWM period start after the shadow load, a worst case of 2^PWM_BITS clocks.
- Simultaneous duty reaching MAX and `level_in`=0: the reversal wins. The state goes to RAMP_DOWN and duty holds at MAX for that step.
- Ramp steps are independent of the PWM period; there is no alignment requirement.

## Configuration

- `LED_FADER_GAMMA_EN` defined: compare = (duty·duty) >> PWM_BITS, computed with 2·PWM_BITS-bit intermediate width, except duty=MAX maps to MAX. This gives a perceptually linear fade.
- `LED_FADER_GAMMA_EN` undefined: compare = duty (linear).
- The `duty` port always shows the un-mapped duty.

## Structure

- `led_fader_pkg`: the `fade_state_t` enum (OFF, RAMP_UP, ON, RAMP_DOWN).
- Sub-module `led_pwm`:
  - Parameter PWM_BITS.
  - Contains the free-running counter, the shadow register loaded at wrap, and the compare with the MAX/0 special cases.
  - Inputs: `clk`, `reset_n`, compare.
  - Output: `led_out`.
- `led_fader` holds the FSM, the step counter, duty, and the optional gamma mapping.

## Test plan

All scenarios use PWM_BITS=4 (MAX=15) and STEP_DIV=2.

1. Reset hold: `reset_n`=0 with `level_in`=1 → `led_out`=0, `busy`=0, `duty`=0 throughout.
2. Full ramp up:
   - Stimulus: `level_in`=1 held.
   - `duty` increments every 2 clocks, 0→15, after 30 clocks in RAMP_UP.
   - Then state is ON and `busy`=0.
   - `led_out` stays constant 1 from the period after the shadow loads 15.
3. PWM ratio: duty frozen at 5 (linear build) → exactly 5 high clocks per 16-clock period.
4. Mid-ramp reversal:
   - Stimulus: `level_in` drops when `duty`=7.
   - `duty` goes 7→6 two clocks later and continues down to 0.
   - Then state is OFF, `busy`=0, and `led_out`=0 constantly.
5. Async reset mid-ramp: assert `reset_n`=0 at `duty`=9 → `led_out`=0 and `duty`=0 within the same cycle with no clock. After release, the ramp restarts from 0.
6. Gamma build, with `LED_FADER_GAMMA_EN` defined: `duty`=8 → compare=4 (4 high clocks per period); `duty`=15 → constant 1.
